// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the RV32 datapath.
// Steps FETCH -> DECODE -> EXEC -> (MEM) -> (WB) over one shared memory port
// with a req/ready handshake, emits per-cycle datapath strobes, counts
// retired instructions and parks in a sticky TRAP on unsupported opcodes.
// Ports:
//   clk, reset (async, active-low)
//   run, opcode[6:0], alu_zero, mem_ready, trap_clear     control inputs
//   mem_req, mem_we, ir_write, pc_write, pc_src, alu_src,
//   alu_operation[3:0], reg_write, mem_to_regs, illegal   datapath strobes
//   instret[CNT_W-1:0]                                     retired count
//   state[STATE_W-1:0]                                     debug state
module multicycle_sequencer #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned STATE_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [6:0]         opcode,
  input  logic               alu_zero,
  input  logic               mem_ready,
  input  logic               trap_clear,
  output logic               mem_req,
  output logic               mem_we,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_src,
  output logic               alu_src,
  output logic [3:0]         alu_operation,
  output logic               reg_write,
  output logic               mem_to_regs,
  output logic               illegal,
  output logic [CNT_W-1:0]   instret,
  output logic [STATE_W-1:0] state
);

  localparam int unsigned ST_W  = 3;
  localparam int unsigned CLS_W = 3;

  localparam logic [ST_W-1:0] S_FETCH  = 3'd0;
  localparam logic [ST_W-1:0] S_DECODE = 3'd1;
  localparam logic [ST_W-1:0] S_EXEC   = 3'd2;
  localparam logic [ST_W-1:0] S_MEM    = 3'd3;
  localparam logic [ST_W-1:0] S_WB     = 3'd4;
  localparam logic [ST_W-1:0] S_TRAP   = 3'd5;

  localparam logic [CLS_W-1:0] C_R      = 3'd0;
  localparam logic [CLS_W-1:0] C_LOAD   = 3'd1;
  localparam logic [CLS_W-1:0] C_STORE  = 3'd2;
  localparam logic [CLS_W-1:0] C_BRANCH = 3'd3;
  localparam logic [CLS_W-1:0] C_ILL    = 3'd4;

  localparam logic [3:0] ALU_ADDR = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_CMP  = 4'd7;

  logic [ST_W-1:0]  state_q, state_d;
  logic [CLS_W-1:0] class_q, class_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [CLS_W-1:0] dec_class_c;
  logic             retire_c;

  // Opcode classification, same decode as the core control unit.
  always_comb begin
    dec_class_c = C_ILL;
    case (opcode)
      7'h33:   dec_class_c = C_R;
      7'h03:   dec_class_c = C_LOAD;
      7'h23:   dec_class_c = C_STORE;
      7'h63:   dec_class_c = C_BRANCH;
      default: dec_class_c = C_ILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (run && mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = (dec_class_c == C_ILL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (class_q)
          C_R:             state_d = S_WB;
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEM:    if (mem_ready) state_d = (class_q == C_LOAD) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   if (trap_clear) state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Strobe outputs; gated by reset so they drop without waiting for a clock.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    alu_src       = 1'b0;
    alu_operation = ALU_ADDR;
    reg_write     = 1'b0;
    mem_to_regs   = 1'b0;
    illegal       = 1'b0;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = run;
          if (run && mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_EXEC: begin
          case (class_q)
            C_R: alu_operation = ALU_ADD;
            C_LOAD, C_STORE: alu_src = 1'b1;
            C_BRANCH: begin
              alu_operation = ALU_CMP;
              pc_write      = alu_zero;
              pc_src        = alu_zero;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          alu_src = 1'b1;
          mem_we  = (class_q == C_STORE);
        end
        S_WB: begin
          reg_write   = 1'b1;
          mem_to_regs = (class_q == C_LOAD);
        end
        S_TRAP:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

  // Class latch and retired-instruction counter.
  always_comb begin
    class_d  = class_q;
    retire_c = 1'b0;
    if (state_q == S_DECODE) class_d = dec_class_c;
    case (state_q)
      S_EXEC:  retire_c = (class_q == C_BRANCH);
      S_MEM:   retire_c = mem_ready && (class_q == C_STORE);
      S_WB:    retire_c = 1'b1;
      default: retire_c = 1'b0;
    endcase
    instret_d = retire_c ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      class_q   <= C_R;
      instret_q <= '0;
    end else begin
      class_q   <= class_d;
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
  assign state   = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: scripted per-instruction
// reference built from the class/phase rules, randomized opcodes, waits and
// noise, plus a CNT_W=4 instance sharing stimulus for counter wrap.
module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       reset, run, alu_zero, mem_ready, trap_clear;
  logic [6:0] opcode;

  logic        mem_req, mem_we, ir_write, pc_write, pc_src, alu_src;
  logic [3:0]  alu_operation;
  logic        reg_write, mem_to_regs, illegal;
  logic [31:0] instret;
  logic [2:0]  state;

  logic        d4_mem_req, d4_mem_we, d4_ir_write, d4_pc_write, d4_pc_src, d4_alu_src;
  logic [3:0]  d4_alu_operation;
  logic        d4_reg_write, d4_mem_to_regs, d4_illegal;
  logic [3:0]  d4_instret;
  logic [2:0]  d4_state;

  multicycle_sequencer #(.CNT_W(32), .STATE_W(3)) u_dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .trap_clear(trap_clear), .mem_req(mem_req), .mem_we(mem_we),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src),
    .alu_operation(alu_operation), .reg_write(reg_write), .mem_to_regs(mem_to_regs),
    .illegal(illegal), .instret(instret), .state(state)
  );

  multicycle_sequencer #(.CNT_W(4), .STATE_W(3)) u_dut4 (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .trap_clear(trap_clear), .mem_req(d4_mem_req), .mem_we(d4_mem_we),
    .ir_write(d4_ir_write), .pc_write(d4_pc_write), .pc_src(d4_pc_src), .alu_src(d4_alu_src),
    .alu_operation(d4_alu_operation), .reg_write(d4_reg_write), .mem_to_regs(d4_mem_to_regs),
    .illegal(d4_illegal), .instret(d4_instret), .state(d4_state)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int unsigned model_cnt = 0;

  logic [12:0] strobes;
  assign strobes = {mem_req, mem_we, ir_write, pc_write, pc_src, alu_src,
                    alu_operation, reg_write, mem_to_regs, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] sb(input logic mreq, input logic mwe, input logic irw,
                                     input logic pcw, input logic pcs, input logic asrc,
                                     input logic [3:0] aop, input logic rw, input logic m2r,
                                     input logic ill);
    return {mreq, mwe, irw, pcw, pcs, asrc, aop, rw, m2r, ill};
  endfunction

  // Inputs are set by the caller just after a rising edge; check mid-cycle, then advance.
  task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [12:0] s);
    #1;
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_strobes"}, 32'(strobes), 32'(s));
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_instret"}, instret, model_cnt);
    check({tag, "_instret4"}, 32'(d4_instret), model_cnt % 16);
  endtask

  task automatic noise();
    mem_ready = 1'($urandom);
    run       = 1'($urandom);
    alu_zero  = 1'($urandom);
    opcode    = 7'($urandom);
  endtask

  // One instruction from FETCH back to FETCH, expectations from the class rules.
  task automatic do_instr(input logic [6:0] opc, input logic zero, input int idle,
                          input int fwait, input int mwait, input int trapc);
    int cls;
    case (opc)
      7'h33:   cls = 0;
      7'h03:   cls = 1;
      7'h23:   cls = 2;
      7'h63:   cls = 3;
      default: cls = 4;
    endcase
    trap_clear = 1'b0;
    for (int i = 0; i < idle; i++) begin
      noise(); run = 1'b0;
      expect_cyc("idle", 3'd0, 13'd0);
    end
    for (int i = 0; i < fwait; i++) begin
      noise(); run = 1'b1; mem_ready = 1'b0;
      expect_cyc("fetch_wait", 3'd0, sb(1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0));
    end
    noise(); run = 1'b1; mem_ready = 1'b1;
    expect_cyc("fetch", 3'd0, sb(1, 0, 1, 1, 0, 0, 4'd0, 0, 0, 0));
    noise(); opcode = opc;
    expect_cyc("decode", 3'd1, 13'd0);
    case (cls)
      0: begin
        noise();
        expect_cyc("exec_r", 3'd2, sb(0, 0, 0, 0, 0, 0, 4'd2, 0, 0, 0));
        noise();
        expect_cyc("wb_r", 3'd4, sb(0, 0, 0, 0, 0, 0, 4'd0, 1, 0, 0));
        model_cnt++;
      end
      1, 2: begin
        noise();
        expect_cyc("exec_ls", 3'd2, sb(0, 0, 0, 0, 0, 1, 4'd0, 0, 0, 0));
        for (int i = 0; i <= mwait; i++) begin
          noise(); mem_ready = (i == mwait);
          expect_cyc("mem", 3'd3, sb(1, cls == 2, 0, 0, 0, 1, 4'd0, 0, 0, 0));
        end
        if (cls == 1) begin
          noise();
          expect_cyc("wb_ld", 3'd4, sb(0, 0, 0, 0, 0, 0, 4'd0, 1, 1, 0));
        end
        model_cnt++;
      end
      3: begin
        noise(); alu_zero = zero;
        expect_cyc("exec_br", 3'd2, sb(0, 0, 0, zero, zero, 0, 4'd7, 0, 0, 0));
        model_cnt++;
      end
      default: begin
        for (int i = 0; i < trapc; i++) begin
          noise(); trap_clear = 1'b0;
          expect_cyc("trap", 3'd5, sb(0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 1));
        end
        noise(); trap_clear = 1'b1;
        expect_cyc("trap_clr", 3'd5, sb(0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 1));
        trap_clear = 1'b0;
      end
    endcase
    #1;
    check("back_to_fetch", 32'(state), 32'd0);
    check_cnt("retire");
  endtask

  logic [6:0] legal_ops [4];

  initial begin
    legal_ops[0] = 7'h33; legal_ops[1] = 7'h03; legal_ops[2] = 7'h23; legal_ops[3] = 7'h63;
    reset = 1'b0; run = 1'b1; mem_ready = 1'b1; trap_clear = 1'b0;
    alu_zero = 1'b0; opcode = 7'h33;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_strobes", 32'(strobes), 32'd0);
    check_cnt("rst");
    reset = 1'b1;

    // Directed cases.
    do_instr(7'h33, 1'b0, 0, 0, 0, 0);
    do_instr(7'h03, 1'b0, 0, 0, 3, 0);
    do_instr(7'h23, 1'b0, 0, 0, 0, 0);
    do_instr(7'h63, 1'b1, 0, 0, 0, 0);
    do_instr(7'h63, 1'b0, 0, 0, 0, 0);
    do_instr(7'h13, 1'b0, 0, 0, 0, 10);

    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      logic [6:0] opc;
      if ($urandom_range(0, 4) == 0) begin
        opc = 7'($urandom);
      end else begin
        opc = legal_ops[$urandom_range(0, 3)];
      end
      do_instr(opc, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 4));
    end

    // Reset in the middle of a store's MEM phase.
    noise(); run = 1'b1; mem_ready = 1'b1;
    expect_cyc("abort_fetch", 3'd0, sb(1, 0, 1, 1, 0, 0, 4'd0, 0, 0, 0));
    noise(); opcode = 7'h23;
    expect_cyc("abort_decode", 3'd1, 13'd0);
    noise();
    expect_cyc("abort_exec", 3'd2, sb(0, 0, 0, 0, 0, 1, 4'd0, 0, 0, 0));
    mem_ready = 1'b0;
    #1;
    check("abort_mem_req_pre", 32'(mem_req), 32'd1);
    check("abort_mem_we_pre", 32'(mem_we), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_state", 32'(state), 32'd0);
    model_cnt = 0;
    check_cnt("abort");
    // Reset wins over a simultaneous trap_clear.
    trap_clear = 1'b1;
    @(posedge clk);
    #1;
    check("rst_vs_clear_state", 32'(state), 32'd0);
    trap_clear = 1'b0;
    reset = 1'b1;

    // Sixteen R-types wrap the 4-bit counter to zero.
    for (int n = 0; n < 16; n++) do_instr(7'h33, 1'b0, 0, 0, 0, 0);
    check("wrap4", 32'(d4_instret), 32'd0);
    check("wrap32", instret, 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the RV32 datapath. It sequences FETCH, DECODE, EXECUTE, MEM and WRITEBACK over a single shared instruction/data memory port with a req/ready handshake.
- It generates per-cycle datapath strobes using the same opcode decode as the core control unit (R-type 0x33, load 0x03, store 0x23, branch 0x63) and counts retired instructions.
- Any unsupported opcode sends it to a sticky trap state.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instret.
- STATE_W, 3, width of the state debug output.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  when high, FETCH may start a new instruction.
- opcode  input  7  instruction register bits [6:0]; valid from DECODE onward.
- alu_zero  input  1  ALU zero flag; sampled in EXECUTE for branches.
- mem_ready  input  1  memory accepts/completes the current request this cycle.
- trap_clear  input  1  leaves TRAP.
- mem_req  output  1  memory request.
- mem_we  output  1  memory write (store).
- ir_write  output  1  load instruction register.
- pc_write  output  1  update PC (PC+4 or branch target).
- pc_src  output  1  0 = PC+4, 1 = branch target.
- alu_src  output  1  0 = rs2, 1 = immediate.
- alu_operation  output  4  2 = add (R-type), 0 = address add, 7 = compare (branch).
- reg_write  output  1  register file write.
- mem_to_regs  output  1  writeback source is memory.
- illegal  output  1  high while in TRAP.
- instret  output  CNT_W  retired-instruction count.
- state  output  STATE_W  current state encoding.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Encodings 6 and 7 are unreachable; if entered, go to FETCH.
- Reset (async assert, reset=0):
  - State = FETCH, instret = 0, opcode class register cleared.
  - All outputs 0.
  - Release is synchronous to clk; first action on the following edge.
- Strobe timing:
  - All strobes are combinational from state, latched class, and inputs.
  - Outputs not listed for a state are 0.
- FETCH:
  - mem_req = run.
  - When run & mem_ready: ir_write = 1, pc_write = 1, pc_src = 0, next = DECODE.
  - Otherwise stay in FETCH. run low idles with no request.
- DECODE:
  - Latch opcode class: R, LOAD, STORE, BRANCH, or ILLEGAL.
  - ILLEGAL → TRAP. Anything else → EXEC.
  - No strobes asserted.
- EXEC:
  - R-type: alu_src = 0, alu_operation = 2; next = WB.
  - LOAD/STORE: alu_src = 1, alu_operation = 0; next = MEM.
  - BRANCH: alu_src = 0, alu_operation = 7.
    - If alu_zero: pc_write = 1, pc_src = 1.
    - instret increments; next = FETCH.
- MEM:
  - mem_req = 1, alu_src = 1, alu_operation = 0; mem_we = 1 only for STORE.
  - Hold all of these stable until mem_ready.
  - On mem_ready: LOAD → WB; STORE → FETCH with instret increment.
- WB:
  - reg_write = 1; mem_to_regs = 1 for LOAD, 0 for R-type.
  - instret increments; next = FETCH.
- TRAP:
  - illegal = 1; no other strobes.
  - On trap_clear → FETCH. instret is not incremented for illegal instructions.
- Handshake rules:
  - mem_req, once raised in MEM, is never dropped before mem_ready.
  - In FETCH, mem_req follows run. Deasserting run while waiting withdraws the request; the memory must tolerate this.
- Counter: instret wraps modulo 2^CNT_W. It increments exactly once per retired instruction.
- Latency with mem_ready tied high:
  - R-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Reset asserted mid-instruction:
  - Immediate return to FETCH; strobes drop asynchronously.
  - No partial write completes; instret is cleared.
- Simultaneous trap_clear and reset: reset wins.

Test Plan:
- Reset, run=1, mem_ready=1, opcode=0x33 → state sequence 0,1,2,4,0; reg_write high only in WB; alu_operation=2 in EXEC; instret=1 after 4 cycles.
- Load 0x03 with mem_ready low for 3 cycles in MEM → mem_req=1 and mem_we=0 held 4 cycles; then WB with mem_to_regs=1; instret increments once.
- Store 0x23 → mem_we=1 in MEM only; reg_write never asserted; instret=1 after 4 cycles.
- Branch 0x63:
  - alu_zero=1 → pc_write=1 with pc_src=1 in EXEC.
  - alu_zero=0 → pc_write=0 in EXEC.
  - Both cases return to FETCH in 3 cycles.
- Opcode 0x13 → TRAP, illegal=1, all strobes 0 for 10 cycles; trap_clear pulse → FETCH; instret unchanged.
- Reset pulsed low during MEM of a store → mem_req and mem_we go 0 without a clock edge; state=0, instret=0. With CNT_W=4, 16 R-type instructions → instret wraps to 0.
